// File: rtl/spi_sram_slave.sv
// ============================================================================
// Module   : spi_sram_slave
// Function : 23LC-style serial SRAM responder (READ/WRITE/RDMR/WRMR), mode 0,
//            sclk/cs_n/mosi oversampled in the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sram_slave #(
  parameter int ADDR_W = 17,
  parameter int PAGE_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic active,
  output logic cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_RDATA   = 3'd3,
    S_WDATA   = 3'd4,
    S_MODE_RD = 3'd5,
    S_MODE_WR = 3'd6,
    S_IGNORE  = 3'd7
  } state_t;

  localparam logic [1:0] c_MODE_BYTE = 2'b00;
  localparam logic [1:0] c_MODE_PAGE = 2'b10;

  logic [2:0]        r_sclk_s;
  logic [1:0]        r_cs_s;
  logic [1:0]        r_mosi_s;
  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [4:0]        r_addr_cnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_mode;
  logic              r_is_read;
  logic              r_rd_pend;
  logic              r_wr_pend;
  logic              r_armed;
  logic              r_miso;
  logic              r_oe;
  logic              r_cmd_err;

  logic [7:0]        mem [2**ADDR_W];

  wire w_rise    = r_sclk_s[1] & ~r_sclk_s[2];
  wire w_fall    = ~r_sclk_s[1] & r_sclk_s[2];
  wire w_mosi    = r_mosi_s[1];
  wire w_cs_high = r_cs_s[1];
  wire [7:0] w_rx_byte = {r_rx[6:0], w_mosi};

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] m);
    if (m == c_MODE_PAGE)
      return {a[ADDR_W-1:PAGE_W], a[PAGE_W-1:0] + PAGE_W'(1)};
    else
      return a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 3'b000;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], sclk};
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_mosi_s <= {r_mosi_s[0], mosi};
    end
  end

  // The write lands one clk after the 8th data bit, while r_addr still points at it
  always_ff @(posedge clk) begin
    if (r_wr_pend)
      mem[r_addr] <= r_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_addr_cnt <= 5'd0;
      r_rx       <= 8'h00;
      r_tx       <= 8'h00;
      r_addr     <= '0;
      r_mode     <= 2'b01;
      r_is_read  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_armed    <= 1'b0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      if (r_rd_pend)
        r_tx <= mem[r_addr];
      if (r_wr_pend) begin
        r_addr <= next_addr(r_addr, r_mode);
        if (r_mode == c_MODE_BYTE)
          r_state <= S_IGNORE;
      end

      // Deselect dominates any sclk edge seen in the same clk
      if (w_cs_high) begin
        r_state   <= S_IDLE;
        r_armed   <= 1'b1;
        r_miso    <= 1'b0;
        r_oe      <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state   <= S_CMD;
              r_bit_cnt <= 3'd0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              r_rx      <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (w_rx_byte)
                  8'h03: begin r_state <= S_ADDR; r_is_read <= 1'b1; r_addr_cnt <= 5'd0; end
                  8'h02: begin r_state <= S_ADDR; r_is_read <= 1'b0; r_addr_cnt <= 5'd0; end
                  8'h05: begin r_state <= S_MODE_RD; r_tx <= {r_mode, 6'b0}; end
                  8'h01: r_state <= S_MODE_WR;
                  default: begin r_state <= S_IGNORE; r_cmd_err <= 1'b1; end
                endcase
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_addr     <= {r_addr[ADDR_W-2:0], w_mosi};
              r_addr_cnt <= r_addr_cnt + 5'd1;
              if (r_addr_cnt == 5'd23) begin
                r_bit_cnt <= 3'd0;
                if (r_is_read) begin
                  r_state   <= S_RDATA;
                  r_rd_pend <= 1'b1;
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              r_oe      <= 1'b1;
              r_miso    <= r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_mode == c_MODE_BYTE) begin
                  r_state <= S_IGNORE;
                end else begin
                  r_addr    <= next_addr(r_addr, r_mode);
                  r_rd_pend <= 1'b1;
                end
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              r_rx      <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7)
                r_wr_pend <= 1'b1;
            end
          end
          S_MODE_RD: begin
            if (w_fall) begin
              r_oe      <= 1'b1;
              r_miso    <= r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7)
                r_tx <= {r_mode, 6'b0};
            end
          end
          S_MODE_WR: begin
            if (w_rise) begin
              r_rx      <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_mode  <= w_rx_byte[7:6];
                r_state <= S_IGNORE;
              end
            end
          end
          S_IGNORE: begin
            if (w_fall) begin
              r_miso <= 1'b0;
              r_oe   <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign miso    = r_miso;
  assign miso_oe = r_oe;
  assign active  = ~r_cs_s[1];
  assign cmd_err = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_slave.sv
// ============================================================================
// Module   : tb_spi_sram_slave
// Function : Directed self-checking bench for spi_sram_slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_sram_slave;

  localparam time c_HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, active, cmd_err;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  logic [7:0] rx, oe, oe_acc;
  int         err_base;

  spi_sram_slave #(.ADDR_W(17), .PAGE_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe),
    .active (active),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n,
                           output logic [7:0] r, output logic [7:0] o);
    r = 8'h00;
    o = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #c_HALF;
      sclk = 1'b1;
      r = {r[6:0], miso};
      o = {o[6:0], miso_oe};
      #c_HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] r, output logic [7:0] o);
    xfer_bits(tx, 8, r, o);
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] r, o;
    xfer(tx, r, o);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a, output logic [7:0] acc);
    logic [7:0] r, o;
    acc = 8'h00;
    xfer(cmd, r, o);     acc |= o;
    xfer(a[23:16], r, o); acc |= o;
    xfer(a[15:8], r, o);  acc |= o;
    xfer(a[7:0], r, o);   acc |= o;
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #c_HALF;
  endtask

  task automatic cs_end();
    #c_HALF;
    cs_n = 1'b1;
    #(c_HALF * 2);
  endtask

  task automatic wrmr(input logic [7:0] m);
    cs_begin(); send(8'h01); send(m); cs_end();
  endtask

  initial begin
    // Reset state
    #60;
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_active", active, 0);
    check("rst_cmd_err", cmd_err, 0);
    #40 rst_n = 1'b1;
    #100;

    // Sequential write then read
    cs_begin();
    check("active_low_cs", active, 1);
    hdr(8'h02, 24'h000010, oe_acc);
    xfer(8'hAA, rx, oe); oe_acc |= oe;
    xfer(8'hBB, rx, oe); oe_acc |= oe;
    xfer(8'hCC, rx, oe); oe_acc |= oe;
    check("wr_oe_quiet", oe_acc, 0);
    cs_end();
    check("active_high_cs", active, 0);

    cs_begin();
    hdr(8'h03, 24'h000010, oe_acc);
    check("rd_hdr_oe", oe_acc, 0);
    xfer(8'h00, rx, oe); check("rd_seq0", rx, 8'hAA); check("rd_seq0_oe", oe, 8'hFF);
    xfer(8'h00, rx, oe); check("rd_seq1", rx, 8'hBB);
    xfer(8'h00, rx, oe); check("rd_seq2", rx, 8'hCC); check("rd_seq2_oe", oe, 8'hFF);
    cs_end();
    check("oe_after_cs", miso_oe, 0);

    // Sequential wrap at top of memory
    cs_begin(); hdr(8'h02, 24'h01FFFF, oe_acc); send(8'h11); send(8'h22); cs_end();
    cs_begin();
    hdr(8'h03, 24'h01FFFF, oe_acc);
    xfer(8'h00, rx, oe); check("wrap_rd0", rx, 8'h11);
    xfer(8'h00, rx, oe); check("wrap_rd1", rx, 8'h22);
    cs_end();
    cs_begin(); hdr(8'h03, 24'h000000, oe_acc); xfer(8'h00, rx, oe); cs_end();
    check("wrap_rd_zero", rx, 8'h22);

    // Page mode
    wrmr(8'h80);
    cs_begin(); send(8'h05); xfer(8'h00, rx, oe); cs_end();
    check("rdmr_page", rx, 8'h80);
    check("rdmr_oe", oe, 8'hFF);
    cs_begin(); hdr(8'h02, 24'h00003F, oe_acc); send(8'h5A); send(8'hA5); cs_end();
    cs_begin(); hdr(8'h03, 24'h000020, oe_acc); xfer(8'h00, rx, oe); cs_end();
    check("page_rd20", rx, 8'hA5);
    cs_begin();
    hdr(8'h03, 24'h00003F, oe_acc);
    xfer(8'h00, rx, oe); check("page_rd3f", rx, 8'h5A);
    xfer(8'h00, rx, oe); check("page_rd_wrap", rx, 8'hA5);
    cs_end();

    // Byte mode: seed 0x100/0x101, then only the first data byte may land
    cs_begin(); hdr(8'h02, 24'h000100, oe_acc); send(8'hEE); send(8'h77); cs_end();
    wrmr(8'h00);
    cs_begin(); hdr(8'h02, 24'h000100, oe_acc); send(8'h01); send(8'h02); send(8'h03); cs_end();
    cs_begin();
    hdr(8'h03, 24'h000100, oe_acc);
    xfer(8'h00, rx, oe); check("byte_rd0", rx, 8'h01); check("byte_rd0_oe", oe, 8'hFF);
    xfer(8'h00, rx, oe); check("byte_rd1", rx, 8'h00); check("byte_rd1_oe", oe, 8'h00);
    cs_end();
    cs_begin(); hdr(8'h03, 24'h000101, oe_acc); xfer(8'h00, rx, oe); cs_end();
    check("byte_keep101", rx, 8'h77);

    // Unsupported command
    wrmr(8'h40);
    err_base = err_pulses;
    cs_begin();
    xfer(8'h9F, rx, oe_acc);
    xfer(8'h02, rx, oe); oe_acc |= oe;
    xfer(8'hFF, rx, oe); oe_acc |= oe;
    cs_end();
    check("cmd_err_pulses", err_pulses - err_base, 1);
    check("cmd_err_oe", oe_acc, 0);
    cs_begin(); hdr(8'h03, 24'h000010, oe_acc); xfer(8'h00, rx, oe); cs_end();
    check("cmd_err_ram", rx, 8'hAA);

    // Deselect partway through a write data byte
    cs_begin();
    hdr(8'h02, 24'h000010, oe_acc);
    send(8'h12);
    xfer_bits(8'h55, 5, rx, oe);
    cs_end();
    cs_begin();
    hdr(8'h03, 24'h000010, oe_acc);
    xfer(8'h00, rx, oe); check("abort_full_byte", rx, 8'h12);
    xfer(8'h00, rx, oe); check("abort_partial", rx, 8'hBB);
    cs_end();

    // Reset in the middle of a page-mode read of 0xCC (bit 3 high)
    wrmr(8'h80);
    cs_begin();
    hdr(8'h03, 24'h000012, oe_acc);
    xfer_bits(8'h00, 4, rx, oe);
    #40;
    check("pre_rst_oe", miso_oe, 1);
    check("pre_rst_miso", miso, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_oe", miso_oe, 0);
    check("mid_rst_miso", miso, 0);
    #18 rst_n = 1'b1;
    cs_end();
    cs_begin(); send(8'h05); xfer(8'h00, rx, oe); cs_end();
    check("post_rst_mode", rx, 8'h40);
    cs_begin();
    hdr(8'h03, 24'h000010, oe_acc);
    xfer(8'h00, rx, oe); check("post_rst_rd0", rx, 8'h12);
    xfer(8'h00, rx, oe); check("post_rst_rd1", rx, 8'hBB);
    cs_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
